// File: rtl/jpeg_seq_pkg.sv
// Shared types and latency constants for the JPEG block sequencer.
package jpeg_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_FILL  = 3'd2,
    SEQ_WAIT  = 3'd3,
    SEQ_HOLD  = 3'd4
  } seq_state_e;

  localparam int QUANT_LAT       = 2;
  localparam int ROWS_PER_BLK    = 8;
  localparam int MATRIX_ROW_LAST = 11;

  // WAIT spans QUANT_LAT + ZZ_LAT + 1 cycles; the down-counter ends at zero.
  function automatic logic [7:0] wait_load(input int zz_lat);
    return 8'(QUANT_LAT + zz_lat);
  endfunction

endpackage

// File: rtl/jpeg_seq_sat_counter.sv
// Saturating up-counter with synchronous clear, used for sequencer performance counts.
module jpeg_seq_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Single-buffered 8x8 block sequencer: quantizer row reads -> zigzag buffer -> entropy coder.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module jpeg_block_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int ZZ_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             buf_input_enable,
  input  logic [7:0]       buf_matrix_row,
  output logic             row_rd_en,
  output logic [2:0]       row_rd_addr,
  output logic             zz_valid,
  input  logic             zz_ready,
  output logic             busy,
  output logic             seq_err,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] WAIT_LOAD = wait_load(ZZ_LAT);
  localparam logic [2:0] ROW_LAST  = 3'(ROWS_PER_BLK - 1);

  seq_state_e r_state;
  logic       r_buf_ie;
  logic       r_rd_en;
  logic [2:0] r_rd_addr;
  logic [7:0] r_wait;
  logic       r_zz_valid;
  logic       r_busy;
  logic       r_seq_err;

  logic w_blk_ready;
  logic w_blk_hs;
  logic w_row_mismatch;

  // Combinational so a block can be taken in the same cycle the output is consumed.
  assign w_blk_ready = ~reset & ~flush &
                       ((r_state == SEQ_IDLE) | ((r_state == SEQ_HOLD) & zz_ready));
  assign w_blk_hs       = blk_valid & w_blk_ready;
  assign w_row_mismatch = (buf_matrix_row != ({5'd0, r_rd_addr} + 8'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= SEQ_IDLE;
      r_buf_ie   <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wait     <= '0;
      r_zz_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (flush) begin
      r_state    <= SEQ_IDLE;
      r_buf_ie   <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wait     <= '0;
      r_zz_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if ((r_state == SEQ_FILL) && w_row_mismatch) begin
        r_seq_err <= 1'b1;
      end
      case (r_state)
        SEQ_IDLE: begin
          if (w_blk_hs) begin
            r_state  <= SEQ_START;
            r_buf_ie <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        SEQ_START: begin
          r_state   <= SEQ_FILL;
          r_buf_ie  <= 1'b0;
          r_rd_en   <= 1'b1;
          r_rd_addr <= '0;
        end
        SEQ_FILL: begin
          if (r_rd_addr == ROW_LAST) begin
            r_state   <= SEQ_WAIT;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wait    <= WAIT_LOAD;
          end else begin
            r_rd_addr <= r_rd_addr + 3'd1;
          end
        end
        SEQ_WAIT: begin
          if (r_wait == 8'd0) begin
            r_state    <= SEQ_HOLD;
            r_zz_valid <= 1'b1;
          end else begin
            r_wait <= r_wait - 8'd1;
          end
        end
        SEQ_HOLD: begin
          if (zz_ready) begin
            r_zz_valid <= 1'b0;
            if (w_blk_hs) begin
              r_state  <= SEQ_START;
              r_buf_ie <= 1'b1;
            end else begin
              r_state <= SEQ_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= SEQ_IDLE;
          r_buf_ie   <= 1'b0;
          r_rd_en    <= 1'b0;
          r_zz_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign blk_ready        = w_blk_ready;
  assign buf_input_enable = r_buf_ie;
  assign row_rd_en        = r_rd_en;
  assign row_rd_addr      = r_rd_addr;
  assign zz_valid         = r_zz_valid;
  assign busy             = r_busy;
  assign seq_err          = r_seq_err;

`ifdef SEQ_PERF_CNT_EN
  logic w_blk_inc;
  logic w_stall_inc;

  assign w_blk_inc   = r_zz_valid & zz_ready;
  assign w_stall_inc = (r_state == SEQ_HOLD) & ~zz_ready;

  jpeg_seq_sat_counter #(.W(CNT_W)) u_blk_cnt (
    .i_clock (clock),
    .i_reset (reset),
    .i_clr   (flush),
    .i_inc   (w_blk_inc),
    .o_count (blk_cnt)
  );

  jpeg_seq_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clock (clock),
    .i_reset (reset),
    .i_clr   (flush),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );
`else
  assign blk_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule
